// File: rtl/bch_128_enc.sv
// ---------------------------------------------------------------------------
// bch_128_enc
//
// Systematic BCH(255,239) t=2 encoder, shortened to (144,128). Produces a
// 144-bit codeword {data, parity} where parity = d(x)*x^16 mod g(x). Parity is
// built by a BITS_PER_CYC-wide unrolled LFSR over 128/BITS_PER_CYC cycles.
// The far end of the link decodes with bch_128_dec.
//
// Ports:
//   clk      in   1        system clock, rising edge
//   reset    in   1        asynchronous, active-high reset
//   enable   in   1        global clock-enable; 0 freezes every register
//   i_valid  in   1        input word present (accepted when o_ready & enable)
//   i_data   in   [0:127]  data word, i_data[0] is the x^127 coefficient
//   o_ready  out  1        encoder idle and able to accept a word
//   o_code   out  [0:143]  {data, parity}; o_code[128] is parity x^15
//   o_valid  out  1        o_code holds a new result (one enabled cycle)
// ---------------------------------------------------------------------------
module bch_128_enc #(
    parameter int          BITS_PER_CYC = 8,
    parameter logic [15:0] G_POLY       = 16'h6F63
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         i_valid,
    input  logic [0:127] i_data,
    output logic         o_ready,
    output logic [0:143] o_code,
    output logic         o_valid
);

    localparam int         CHUNKS   = 128 / BITS_PER_CYC;
    localparam logic [6:0] LAST_CNT = 7'(CHUNKS - 1);

    // Reject unsupported fold widths while elaborating.
    generate
        if (!((BITS_PER_CYC == 1) || (BITS_PER_CYC == 2) || (BITS_PER_CYC == 4) ||
              (BITS_PER_CYC == 8) || (BITS_PER_CYC == 16) || (BITS_PER_CYC == 32))) begin : g_bad_bits_per_cyc
            $error("bch_128_enc: BITS_PER_CYC must be 1, 2, 4, 8, 16 or 32");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [6:0]     cnt_q, cnt_d;
    logic [15:0]    lfsr_q, lfsr_d;
    logic [0:127]   data_q, data_d;
    logic [0:143]   code_q, code_d;
    logic           valid_q, valid_d;

    logic [0:127]   data_rot_s;
    logic [15:0]    lfsr_nxt_s;
    logic           done_s;

    // Unrolled serial division step: fold bits[0] (highest degree) first.
    function automatic logic [15:0] lfsr_fold(input logic [15:0]             lfsr_in,
                                              input logic [0:BITS_PER_CYC-1] bits);
        logic [15:0] l;
        logic        fb;
        l = lfsr_in;
        for (int i = 0; i < BITS_PER_CYC; i++) begin
            fb = l[15] ^ bits[i];
            l  = {l[14:0], 1'b0} ^ (fb ? G_POLY : 16'h0000);
        end
        return l;
    endfunction

    // The data register is rotated rather than shifted, so after the last
    // chunk it is back to the captured word and no second copy is needed.
    always_comb begin
        data_rot_s = {data_q[BITS_PER_CYC:127], data_q[0:BITS_PER_CYC-1]};
        lfsr_nxt_s = lfsr_fold(lfsr_q, data_q[0:BITS_PER_CYC-1]);
        done_s     = (state_q == ST_BUSY) && (cnt_q == LAST_CNT);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else if (enable) begin
            state_q <= state_d;
        end else begin
            state_q <= state_q;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (done_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: capture on accept, fold one chunk per BUSY cycle.
    always_comb begin
        data_d  = data_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    data_d = i_data;
                    lfsr_d = 16'h0000;
                    cnt_d  = 7'd0;
                end else begin
                    data_d = data_q;
                end
            end
            ST_BUSY: begin
                data_d = data_rot_s;
                lfsr_d = lfsr_nxt_s;
                cnt_d  = cnt_q + 7'd1;
                if (done_s) begin
                    code_d  = {data_rot_s, lfsr_nxt_s};
                    valid_d = 1'b1;
                end else begin
                    valid_d = 1'b0;
                end
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    // Datapath registers; everything freezes while enable is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= 128'h0;
            lfsr_q  <= 16'h0000;
            cnt_q   <= 7'd0;
            code_q  <= 144'h0;
            valid_q <= 1'b0;
        end else if (enable) begin
            data_q  <= data_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            valid_q <= valid_d;
        end else begin
            data_q  <= data_q;
            lfsr_q  <= lfsr_q;
            cnt_q   <= cnt_q;
            code_q  <= code_q;
            valid_q <= valid_q;
        end
    end

    // Output logic.
    always_comb begin
        o_code  = code_q;
        o_valid = valid_q;
        case (state_q)
            ST_IDLE: o_ready = 1'b1;
            ST_BUSY: o_ready = 1'b0;
            default: o_ready = 1'b0;
        endcase
    end

endmodule
